// File: rtl/hr_pkg.sv
// hr_pkg: shared widths, rate scale and FSM state type for heart_period_meter
package hr_pkg;
  localparam int BPM_W = 8;
  localparam logic [BPM_W-1:0] BPM_MAX = 8'd255;
  localparam int unsigned BPM_SCALE = 60;
  typedef enum logic [1:0] {IDLE, RUN, DIV} hr_state_t;
endpackage

// File: rtl/hr_divider.sv
// hr_divider: sequential restoring divider, one quotient bit per cycle, done CNT_W+1 cycles after start
module hr_divider #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [CNT_W-1:0] quotient,
  output logic             done
);
  localparam int IW = $clog2(CNT_W + 1);
  logic [CNT_W-1:0] rem, dvs;
  logic [IW-1:0] i;
  logic [CNT_W:0] sh, diff;
  always_comb begin
    sh = {rem, quotient[CNT_W-1]};
    diff = sh - {1'b0, dvs};
  end
  always_ff @(posedge clk)
    if (rst) begin
      rem <= '0;
      dvs <= '0;
      quotient <= '0;
      i <= '0;
      done <= 1'b0;
    end else begin
      done <= i == IW'(1);
      if (start) begin
        rem <= '0;
        dvs <= divisor;
        quotient <= dividend;
        i <= IW'(CNT_W);
      end else if (i != '0) begin
        rem <= diff[CNT_W] ? sh[CNT_W-1:0] : diff[CNT_W-1:0];
        quotient <= {quotient[CNT_W-2:0], ~diff[CNT_W]};
        i <= i - 1'b1;
      end
    end
endmodule

// File: rtl/heart_period_meter.sv
// heart_period_meter: beat-to-beat period and BPM meter; HR_GLITCH_FILTER_EN adds an input stability filter
module heart_period_meter
  import hr_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int          CNT_W          = 32,
  parameter int unsigned MIN_PERIOD_CYC = CLK_HZ / 4,
  parameter int unsigned MAX_PERIOD_CYC = CLK_HZ * 3,
  parameter int unsigned FILTER_CYC     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] period,
  output logic [BPM_W-1:0] bpm,
  output logic             bpm_valid,
  output logic             beat,
  output logic             lost
);
  localparam logic [CNT_W-1:0] DIVIDEND = CNT_W'(64'(BPM_SCALE) * 64'(CLK_HZ));
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PERIOD_CYC);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PERIOD_CYC);
  if (MIN_PERIOD_CYC <= CNT_W + 2 || FILTER_CYC < 1) begin : g_bad_params
    $error("heart_period_meter: MIN_PERIOD_CYC must exceed CNT_W+2 and FILTER_CYC must be nonzero");
  end
  logic s1, s2, lvl, prev, edge_r;
  always_ff @(posedge clk)
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pulse_in;
      s2 <= s1;
    end
`ifdef HR_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_CYC + 1);
  logic [FW-1:0] fcnt;
  logic filt;
  always_ff @(posedge clk)
    if (rst) begin
      fcnt <= '0;
      filt <= 1'b0;
    end else if (s2 == filt) fcnt <= '0;
    else if (fcnt == FW'(FILTER_CYC - 1)) begin
      filt <= s2;
      fcnt <= '0;
    end else fcnt <= fcnt + 1'b1;
  assign lvl = filt;
`else
  assign lvl = s2;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      prev <= 1'b0;
      edge_r <= 1'b0;
    end else begin
      prev <= lvl;
      edge_r <= lvl & ~prev;
    end
  hr_state_t state, state_n;
  logic acc, meas, tmo, fin, div_start, div_done;
  logic [CNT_W-1:0] cnt, quotient;
  hr_divider #(.CNT_W(CNT_W)) u_div (
    .clk(clk),
    .rst(rst),
    .start(div_start),
    .dividend(DIVIDEND),
    .divisor(period),
    .quotient(quotient),
    .done(div_done)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // an edge at cnt == MAX still passes the MIN check, so it wins over the timeout
  always_comb begin
    state_n = state;
    acc = 1'b0;
    meas = 1'b0;
    tmo = 1'b0;
    fin = 1'b0;
    case (state)
      IDLE: if (edge_r) begin
        acc = 1'b1;
        state_n = RUN;
      end
      RUN: if (edge_r && cnt >= MIN_C) begin
        acc = 1'b1;
        meas = 1'b1;
        state_n = DIV;
      end else if (cnt == MAX_C) begin
        tmo = 1'b1;
        state_n = IDLE;
      end
      DIV: if (div_done) begin
        fin = 1'b1;
        state_n = RUN;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      period <= '0;
      bpm <= '0;
      bpm_valid <= 1'b0;
      beat <= 1'b0;
      lost <= 1'b1;
      div_start <= 1'b0;
    end else begin
      beat <= acc;
      div_start <= meas;
      bpm_valid <= fin;
      cnt <= acc ? CNT_W'(1) : (state == IDLE || tmo) ? '0 : (cnt == MAX_C) ? cnt : cnt + 1'b1;
      period <= meas ? cnt : period;
      lost <= acc ? 1'b0 : tmo ? 1'b1 : lost;
      bpm <= fin ? (|quotient[CNT_W-1:BPM_W] ? BPM_MAX : quotient[BPM_W-1:0]) : tmo ? '0 : bpm;
    end
endmodule

// File: tb/tb_heart_period_meter.sv
// tb_heart_period_meter: directed and random beat intervals checked against an interval-level rate model
module tb_heart_period_meter;
  localparam int CNT_W = 20;
  localparam int MIN = 250;
  localparam int MAX = 3000;
  localparam int SCALE = 60000;
`ifdef HR_GLITCH_FILTER_EN
  localparam int LAT = 3 + 16;
`else
  localparam int LAT = 3;
`endif
  logic clk = 1'b0, rst = 1'b1, pulse_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [7:0] bpm;
  logic bpm_valid, beat, lost;
  int cyc = 0, nvalid = 0, nbeat = 0, n_vec = 0, n_err = 0;
  int last_rise = 0, last_acc = 0, ref_period = 0, ref_bpm = 0, exp_valid = 0, exp_beat = 0;
  bit ref_lost = 1'b1;
  heart_period_meter #(
    .CLK_HZ(1000), .CNT_W(CNT_W), .MIN_PERIOD_CYC(MIN), .MAX_PERIOD_CYC(MAX), .FILTER_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .period(period), .bpm(bpm),
    .bpm_valid(bpm_valid), .beat(beat), .lost(lost)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bpm_valid === 1'b1) nvalid <= nvalid + 1;
    if (beat === 1'b1) nbeat <= nbeat + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int exp_bpm(input int d);
    return (SCALE / d > 255) ? 255 : SCALE / d;
  endfunction
  task automatic model_pre(input int t);
    if (!ref_lost && t - last_acc > MAX) begin
      ref_lost = 1'b1;
      ref_bpm = 0;
    end
  endtask
  task automatic rise(input int gap, input bit abort);
    int t, d;
    bit acc, meas;
    do @(negedge clk); while (cyc - last_rise < gap);
    t = cyc;
    last_rise = t;
    model_pre(t);
    d = t - last_acc;
    acc = ref_lost || d >= MIN;
    meas = acc && !ref_lost;
    pulse_in = 1'b1;
    repeat (LAT + 1) @(posedge clk);
    #1;
    chk("bpm_hold", bpm, ref_bpm);
    if (acc) begin
      exp_beat++;
      last_acc = t;
      ref_lost = 1'b0;
    end
    if (meas) begin
      ref_period = d;
      ref_bpm = exp_bpm(d);
    end
    chk("beat", beat, acc);
    chk("period", period, ref_period);
    chk("lost", lost, ref_lost);
    @(negedge clk) pulse_in = 1'b0;
    if (abort) begin
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      ref_lost = 1'b1;
      ref_period = 0;
      ref_bpm = 0;
      chk("rst_period", period, ref_period);
      chk("rst_bpm", bpm, ref_bpm);
      chk("rst_lost", lost, ref_lost);
      chk("rst_beat", beat, 0);
      chk("rst_valid", bpm_valid, 0);
      repeat (CNT_W + 5) @(posedge clk);
      #1;
    end else if (meas) begin
      repeat (CNT_W + 1) @(posedge clk);
      #1;
      chk("valid_early", bpm_valid, 0);
      @(posedge clk);
      #1;
      chk("bpm_valid", bpm_valid, 1);
      chk("bpm", bpm, ref_bpm);
      exp_valid++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("nbeat", nbeat, exp_beat);
    chk("nvalid", nvalid, exp_valid);
  endtask
  task automatic timeout_check();
    do @(negedge clk); while (cyc - last_acc < MAX - 10);
    chk("pre_to_lost", lost, 0);
    do @(negedge clk); while (cyc - last_acc < MAX + 10);
    model_pre(cyc);
    chk("to_lost", lost, ref_lost);
    chk("to_bpm", bpm, ref_bpm);
    chk("to_nvalid", nvalid, exp_valid);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst0_period", period, 0);
    chk("rst0_bpm", bpm, 0);
    chk("rst0_valid", bpm_valid, 0);
    chk("rst0_beat", beat, 0);
    chk("rst0_lost", lost, 1);
    rst = 1'b0;
    last_rise = cyc;
    rise(100, 0);
    rise(1000, 0);
    rise(500, 0);
    rise(250, 0);
    rise(333, 0);
    rise(200, 0);
    rise(800, 0);
    rise(249, 0);
    rise(251, 0);
    rise(3000, 0);
    timeout_check();
    rise(10, 0);
    rise(1000, 0);
    rise(700, 1);
    rise(40, 0);
    rise(400, 0);
    for (int k = 0; k < 12; k++) rise(int'($urandom_range(150, 3300)), 0);
`ifdef HR_GLITCH_FILTER_EN
    @(negedge clk) pulse_in = 1'b1;
    repeat (10) @(negedge clk);
    pulse_in = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("glitch_nbeat", nbeat, exp_beat);
    chk("glitch_period", period, ref_period);
    rise(600, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/heart_period_meter.md
# heart_period_meter

Measures the interval between successive heartbeat pulses on an asynchronous sensor input and converts it to beats per minute. It is the receive side of the project's slow pulse interface: divider-generated or sensor pulses in, measured period and BPM out. It feeds the display/LED logic and takes its clock directly from the board oscillator.

## Interface
- CLK_HZ, 50_000_000: frequency of clk in Hz.
- CNT_W, 32: period counter and divider width. 60*CLK_HZ must be less than 2^CNT_W.
- MIN_PERIOD_CYC, CLK_HZ/4: refractory period. Edges closer than this are ignored, which caps the rate at 240 BPM.
- MAX_PERIOD_CYC, CLK_HZ*3: timeout. No beat within this interval means signal lost (20 BPM floor).
- FILTER_CYC, 16: glitch-filter stable length. Used only with HR_GLITCH_FILTER_EN.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pulse_in  in  1  asynchronous heartbeat pulse, rising edge = beat.
- period  out  CNT_W  last measured beat-to-beat interval in clk cycles.
- bpm  out  8  last computed rate, truncated, saturating at 255.
- bpm_valid  out  1  one-cycle strobe when bpm updates.
- beat  out  1  one-cycle strobe per accepted beat.
- lost  out  1  level; high when no valid beat reference exists.

## Operation
- pulse_in passes through a 2-FF synchronizer, then a rising-edge detector (registered previous value).
- Free counter cnt:
  - set to 1 on an accepted edge;
  - otherwise increments each cycle in RUN/DIV, saturating at MAX_PERIOD_CYC;
  - held at 0 in IDLE.
- FSM states: IDLE, RUN, DIV.
  - **IDLE:** any rising edge is accepted. Then beat=1, lost=0, go to RUN. No measurement is taken.
  - **RUN, edge with cnt >= MIN_PERIOD_CYC:** accepted. beat=1, period<=cnt, the divider starts with 60*CLK_HZ / cnt, go to DIV.
  - **RUN, edge with cnt < MIN_PERIOD_CYC:** ignored. No beat, cnt keeps counting.
  - **RUN, cnt reaches MAX_PERIOD_CYC:** lost=1, bpm<=0, go to IDLE. No bpm_valid.
  - **DIV:** cnt keeps counting. When the divider finishes, bpm<=min(quotient,255), bpm_valid=1, go to RUN. MIN_PERIOD_CYC > CNT_W+2 is a parameter constraint, so no accepted edge can arrive in DIV.
- Arithmetic:
  - unsigned restoring division, one quotient bit per cycle;
  - quotient truncated;
  - any quotient bit above bit 7 forces bpm=255.

## Timing
- Reset values: period=0, bpm=0, bpm_valid=0, beat=0, lost=1, state IDLE, cnt=0, synchronizer and edge registers 0.
- If pulse_in is already high at reset release, that is detected as an edge, by design.
- beat asserts 3 cycles after the first clk edge that samples pulse_in high.
- period updates in the beat cycle.
- bpm and bpm_valid update exactly CNT_W+2 cycles after beat.
- rst during DIV aborts the division. No bpm_valid is produced and all outputs take their reset values on the next cycle.
- Timeout and edge in the same cycle: the edge wins, since cnt == MAX_PERIOD_CYC still satisfies the MIN check.

## Configuration
- HR_GLITCH_FILTER_EN defined:
  - The synchronized input must be stable for FILTER_CYC consecutive cycles before the filtered level changes.
  - Edge detection uses the filtered level.
  - beat latency becomes 3+FILTER_CYC cycles.
  - Pulses shorter than FILTER_CYC are never seen.
- Not defined: the filter logic is absent, and edge detection uses the raw synchronized level.

## Structure
- Package hr_pkg holds:
  - BPM_W=8 and BPM_MAX=255;
  - the state typedef (IDLE, RUN, DIV);
  - the BPM_SCALE constant 60 used to form the dividend.
- One sub-module, hr_divider: CNT_W-bit sequential restoring divider.
  - Ports: clk, rst, start, dividend, divisor, quotient, done.
  - done is a one-cycle strobe CNT_W+1 cycles after start.

## Test plan
Test parameters: CLK_HZ=1000, CNT_W=20, MIN=250, MAX=3000, so the dividend is 60000.
- Edges every 1000 cycles: first edge gives beat only, lost falls. Second edge gives period=1000, then bpm=60 with bpm_valid CNT_W+2 cycles after beat.
- Edges at interval 500 give bpm=120. Interval 250 gives bpm=240. Interval 333 gives bpm=180 (truncated).
- Edge 200 cycles after a beat: no beat, period unchanged. The next edge at 1000 from the last accepted beat gives period=1000.
- No edge for 3000 cycles after a beat: lost=1, bpm=0, no bpm_valid. The next edge gives beat with lost=0 and no bpm.
- rst asserted 5 cycles into DIV: no bpm_valid, all outputs return to reset values, lost=1.
- With HR_GLITCH_FILTER_EN: a 10-cycle high glitch produces no beat, and a 20-cycle pulse produces beat at 3+16 cycles.
